clk_step_ctrl: RTL and testbench
================================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter CNT_W, default 26, SHALL set the width of the free-running prescale counter.
REQ-002 Parameter DB_CYCLES, default 50000, SHALL set the number of stable clock cycles required to accept a new step_btn level.
REQ-003 clockin  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 run_req  input  1  SHALL be a one-cycle synchronous pulse requesting the RUN state.
REQ-006 halt_req  input  1  SHALL be a one-cycle synchronous pulse requesting the HALT state.
REQ-007 step_btn  input  1  SHALL be the raw, asynchronous, bouncing single-step pushbutton, active-high.
REQ-008 div_sel  input  5  SHALL select the prescale tap, giving a tick period of 2^(div_sel+1) cycles.
REQ-009 fclk_only  input  1  SHALL bypass division in RUN when 1.
REQ-010 clk_en  output  1  SHALL be the clock-enable pulse to the sequenced MCU.
REQ-011 halted  output  1  SHALL be 1 while in HALT.
REQ-012 en_count  output  16  SHALL count asserted clk_en cycles.

Function
REQ-013 The prescale counter SHALL increment by 1 every cycle, free-running, wrapping from 2^CNT_W-1 to 0.
REQ-014 The effective tap SHALL be min(div_sel, CNT_W-1).
REQ-015 A tick SHALL be a one-cycle pulse on the cycle after the selected tap bit goes 0->1, detected against a registered copy of the tap.
REQ-016 On any cycle where div_sel differs from its registered value, the tap-history register SHALL load the new tap value, and no tick SHALL be generated that cycle.
REQ-017 step_btn SHALL pass through a 2-flop synchronizer followed by a debouncer: the debounced level changes only after the synchronized input holds the opposite level for DB_CYCLES consecutive cycles.
REQ-018 A step event SHALL be a one-cycle pulse on the debounced 0->1 edge; the 1->0 edge SHALL produce nothing.
REQ-019 The FSM SHALL have exactly three states: HALT, RUN, STEP.
REQ-020 HALT: clk_en=0 and halted=1; halt_req is ignored; run_req -> RUN; a step event -> STEP.
REQ-021 RUN: clk_en=1 every cycle if fclk_only=1, else clk_en=tick; halt_req -> HALT; step events are ignored.
REQ-022 STEP: clk_en=1 for exactly one cycle, halted=0; next state is HALT unconditionally, and run_req/halt_req are ignored.
REQ-023 If run_req and halt_req are both asserted in RUN or HALT, halt SHALL win.
REQ-024 If run_req and a step event coincide in HALT, run SHALL win, and the step event SHALL be discarded.
REQ-025 clk_en SHALL be a registered output; state-driven changes take effect the cycle after the causing input.
REQ-026 en_count SHALL increment on every cycle clk_en=1 and wrap from 0xFFFF to 0x0000.
REQ-027 halted SHALL be registered and consistent with the current state.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately force:
  - state=HALT, clk_en=0, halted=1, en_count=0
  - prescale counter=0, tap history=0
  - synchronizer, debounced level and debounce counter=0
REQ-029 Reset mid-STEP or mid-debounce SHALL abort the operation, and no clk_en pulse SHALL follow reset release.
REQ-030 After reset_n deasserts, the block SHALL accept inputs on the first rising clock edge.

Verification
REQ-031 Reset, run_req pulse, div_sel=2, fclk_only=0 -> clk_en pulses exactly every 8 cycles; en_count=4 after 32 cycles of RUN.
REQ-032 In RUN, fclk_only=1 for 10 cycles -> clk_en=1 on all 10 cycles; en_count advances by 10.
REQ-033 In HALT, DB_CYCLES=4, step_btn bounces 0/1 for 3 cycles, then holds 1 for 20 cycles -> exactly one clk_en pulse, halted=0 only on that cycle, en_count +1.
REQ-034 In RUN, run_req and halt_req asserted on the same cycle -> HALT; clk_en=0 and halted=1 from the next cycle.
REQ-035 In RUN, div_sel changes 0->3 -> no clk_en on the change cycle; the next pulse follows the new 16-cycle period.
REQ-036 Assert reset_n on the STEP cycle -> clk_en=0 immediately, en_count=0, halted=1, and no step pulse after release.

Source files
------------

// File: rtl/clk_step_ctrl.sv
// Clock-enable sequencer for a stepped MCU: HALT / free RUN at a prescaled rate / single STEP
// triggered by a debounced pushbutton. en_count tallies every cycle clk_en was asserted.
module clk_step_ctrl #(
  parameter int CNT_W     = 26,
  parameter int DB_CYCLES = 50000
) (
  input  logic        clockin,
  input  logic        reset_n,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        step_btn,
  input  logic [4:0]  div_sel,
  input  logic        fclk_only,
  output logic        clk_en,
  output logic        halted,
  output logic [15:0] en_count,
  output logic [1:0]  dbg_state
);

  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tap_q, tap_d;
  logic [4:0]        div_sel_q, div_sel_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_level_q, db_level_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              clk_en_q, clk_en_d;
  logic              halted_q, halted_d;
  logic [15:0]       en_count_q, en_count_d;

  int   eff_tap;
  logic tap;
  logic div_change;
  logic tick;
  logic db_flip;
  logic step_ev;

  // Prescaler and tap edge detection; a div_sel change reloads the history and masks the tick.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    eff_tap = (int'(div_sel) > CNT_W - 1) ? CNT_W - 1 : int'(div_sel);
    tap     = 1'b0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i == eff_tap) tap = cnt_q[i];
    end
    div_change = (div_sel != div_sel_q);
    tap_d      = tap;
    div_sel_d  = div_sel;
    tick       = tap & ~tap_q & ~div_change;
  end

  // Button path: two-flop synchronizer, then a level that only moves after DB_CYCLES stable samples.
  always_comb begin
    sync1_d    = step_btn;
    sync2_d    = sync1_q;
    db_flip    = (sync2_q != db_level_q) && (db_cnt_q == DB_LAST);
    db_level_d = db_flip ? sync2_q : db_level_q;
    if ((sync2_q == db_level_q) || db_flip) begin
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
    step_ev = db_flip & sync2_q;
  end

  // Next state plus registered outputs derived from the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (run_req && !halt_req) begin
          state_d = ST_RUN;
        end else if (step_ev && !run_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req) state_d = ST_HALT;
      end
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase

    clk_en_d = 1'b0;
    case (state_d)
      ST_RUN:  clk_en_d = fclk_only | tick;
      ST_STEP: clk_en_d = 1'b1;
      default: clk_en_d = 1'b0;
    endcase
    halted_d   = (state_d == ST_HALT);
    en_count_d = en_count_q + {15'd0, clk_en_d};
  end

  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HALT;
      cnt_q      <= '0;
      tap_q      <= 1'b0;
      div_sel_q  <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      clk_en_q   <= 1'b0;
      halted_q   <= 1'b1;
      en_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tap_q      <= tap_d;
      div_sel_q  <= div_sel_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      clk_en_q   <= clk_en_d;
      halted_q   <= halted_d;
      en_count_q <= en_count_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign halted    = halted_q;
  assign en_count  = en_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Bench for clk_step_ctrl: directed scenarios plus random traffic, all checked against a
// cycle-indexed reference model of prescaler, debounce window and HALT/RUN/STEP behaviour.
module tb_clk_step_ctrl;

  localparam int CNT_W = 8;
  localparam int DB    = 4;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

  logic        clockin  = 1'b0;
  logic        reset_n  = 1'b1;
  logic        run_req  = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_btn = 1'b0;
  logic [4:0]  div_sel  = 5'd0;
  logic        fclk_only = 1'b0;
  logic        clk_en;
  logic        halted;
  logic [15:0] en_count;
  logic [1:0]  dbg_state;

  clk_step_ctrl #(.CNT_W(CNT_W), .DB_CYCLES(DB)) dut (
    .clockin   (clockin),
    .reset_n   (reset_n),
    .run_req   (run_req),
    .halt_req  (halt_req),
    .step_btn  (step_btn),
    .div_sel   (div_sel),
    .fclk_only (fclk_only),
    .clk_en    (clk_en),
    .halted    (halted),
    .en_count  (en_count),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clockin = ~clockin;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: n counts edges since reset release
  int n;
  int m_mode;
  bit m_en, m_halt;
  int m_cnt;
  int m_div_prev;
  bit m_lvl;
  bit dly[$];
  bit win[$];

  task automatic model_reset();
    n = 0; m_mode = M_HALT; m_en = 0; m_halt = 1; m_cnt = 0; m_div_prev = 0; m_lvl = 0;
    dly.delete(); win.delete();
    dly.push_back(1'b0); dly.push_back(1'b0);
    for (int i = 0; i < DB; i++) win.push_back(1'b0);
  endtask

  task automatic model_edge();
    int k, cur, prv;
    bit tick, s, ev, all_opp;
    k    = (int'(div_sel) > CNT_W - 1) ? CNT_W - 1 : int'(div_sel);
    cur  = n % (1 << CNT_W);
    prv  = (n + (1 << CNT_W) - 1) % (1 << CNT_W);
    tick = (((cur >> k) & 1) == 1) && !(n > 0 && ((prv >> k) & 1) == 1)
           && (int'(div_sel) == m_div_prev);
    s = dly.pop_front();
    dly.push_back(step_btn);
    win.push_back(s);
    if (win.size() > DB) void'(win.pop_front());
    all_opp = 1;
    foreach (win[i]) if (win[i] == m_lvl) all_opp = 0;
    ev = 0;
    if (all_opp) begin
      m_lvl = !m_lvl;
      ev = m_lvl;
    end
    if (m_mode == M_HALT) begin
      if (run_req && !halt_req) m_mode = M_RUN;
      else if (ev && !run_req) m_mode = M_STEP;
    end else if (m_mode == M_RUN) begin
      if (halt_req) m_mode = M_HALT;
    end else begin
      m_mode = M_HALT;
    end
    m_en   = (m_mode == M_RUN) ? (fclk_only || tick) : (m_mode == M_STEP);
    m_halt = (m_mode == M_HALT);
    m_cnt  = (m_cnt + int'(m_en)) % 65536;
    m_div_prev = int'(div_sel);
    n++;
    exp_q.push_back({m_en, m_halt, 16'(m_cnt)});
  endtask

  // driver tasks
  task automatic cycle();
    logic [17:0] e;
    model_edge();
    @(posedge clockin);
    #1;
    e = exp_q.pop_front();
    check("clk_en", clk_en, e[17]);
    check("halted", halted, e[16]);
    check("en_count", en_count, e[15:0]);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_clk_en", clk_en, 0);
    check("rst_halted", halted, 1);
    check("rst_en_count", en_count, 0);
    exp_q.delete();
    @(posedge clockin);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  int pulses, last, lows;
  logic [15:0] start;

  initial begin
    #2;
    do_reset();

    // div_sel=2: 32 cycles of RUN hold exactly four pulses, eight apart
    div_sel = 5'd2; fclk_only = 1'b0;
    cycle(); cycle();
    pulses = 0; last = -1;
    for (int i = 0; i < 32; i++) begin
      run_req = (i == 0);
      cycle();
      if (clk_en) begin
        pulses++;
        if (last >= 0) check("div2_gap", i - last, 8);
        last = i;
      end
    end
    run_req = 1'b0;
    check("div2_pulses", pulses, 4);
    check("div2_en_count", en_count, 4);

    // fclk_only: enable on every cycle
    fclk_only = 1'b1; start = en_count; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (clk_en) pulses++;
    end
    fclk_only = 1'b0;
    check("fclk_pulses", pulses, 10);
    check("fclk_delta", 16'(en_count - start), 10);

    // div_sel 0 -> 3: masked change cycle, then 16-cycle period
    div_sel = 5'd0;
    for (int i = 0; i < 4; i++) cycle();
    div_sel = 5'd3;
    cycle();
    check("divchg_no_pulse", clk_en, 0);
    last = -1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (clk_en) begin
        if (last >= 0) check("divchg_gap", i - last, 16);
        else check("divchg_first", (i < 16), 1);
        last = i;
      end
    end

    // run+halt together: halt wins in RUN and in HALT
    run_req = 1'b1; halt_req = 1'b1;
    cycle();
    run_req = 1'b0; halt_req = 1'b0;
    check("both_run_halted", halted, 1);
    check("both_run_clk_en", clk_en, 0);
    run_req = 1'b1; halt_req = 1'b1;
    cycle();
    run_req = 1'b0; halt_req = 1'b0;
    check("both_halt_halted", halted, 1);

    // bouncing button then held: one STEP pulse, release does nothing
    pulses = 0; lows = 0; start = en_count;
    for (int i = 0; i < 23; i++) begin
      step_btn = (i < 3) ? 1'(i % 2) : 1'b1;
      cycle();
      if (clk_en) pulses++;
      if (!halted) lows++;
    end
    check("step_pulses", pulses, 1);
    check("step_unhalted", lows, 1);
    check("step_delta", 16'(en_count - start), 1);
    step_btn = 1'b0; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (clk_en) pulses++;
    end
    check("release_pulses", pulses, 0);

    // run_req coinciding with the step event: RUN entered, no STEP
    step_btn = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    check("run_wins_halted", halted, 0);
    cycle(); cycle();
    check("run_wins_stays", halted, 0);
    halt_req = 1'b1;
    cycle();
    halt_req = 1'b0; step_btn = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // reset landing on the STEP cycle
    step_btn = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("pre_rst_step", clk_en, 1);
    step_btn = 1'b0;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (clk_en) pulses++;
    end
    check("post_rst_pulses", pulses, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      run_req  = ($urandom_range(0, 29) == 0);
      halt_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0)
        div_sel = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) fclk_only = ~fclk_only;
      if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
      cycle();
      if ($urandom_range(0, 999) == 0) begin
        run_req = 1'b0; halt_req = 1'b0;
        do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
